// File: rtl/sprinkler_pkg.sv
// Shared definitions for the sprinkler duration counter chain.
//   state_t   : cycle controller state encoding (also seen on its state output)
//   BCD_ZERO  : value of a BCD digit reading zero
//   is_bcd()  : true when a 4-bit digit holds a legal BCD value (0..9)
// Reused by the counter and display blocks as well as the cycle controller.
package sprinkler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_IRRIGATE = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam logic [3:0] BCD_ZERO = 4'h0;

    function automatic logic is_bcd(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/sprinkler_cycle_controller_tick_prescaler.sv
// Free-running tick prescaler.
//   clk   in  : system clock, rising edge
//   reset in  : asynchronous, active-low
//   clear in  : synchronous restart; count returns to 0 on the next edge
//   en    in  : count enable
//   tick  out : high for the single cycle in which the count holds TICK_DIV-1
// The count runs 0..TICK_DIV-1 and wraps; tick is a flop that tracks the
// count so it is aligned with the cycle holding the terminal value.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (clear) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Count becomes LAST on this edge exactly when it now holds LAST-1.
            tick_q <= (cnt_q == LAST - CW'(1));
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sprinkler_cycle_controller.sv
// Sprinkler irrigation cycle controller (initiator side of the BCD
// duration counter chain).
//   clk        in  : system clock, rising edge
//   reset      in  : asynchronous, active-low; clears all state and outputs
//   start_req  in  : level, soil dry -> request a cycle
//   abort      in  : level, terminate an active irrigation
//   cnt_tens   in  : BCD tens digit from the counter
//   cnt_units  in  : BCD units digit from the counter
//   load_pulse out : one-cycle preset strobe to both counter digits
//   cnt_tick   out : one-cycle count enable to the units digit
//   valve_on   out : valve drive
//   busy       out : high in every state except IDLE and FAULT
//   done       out : one-cycle pulse when the counters reach 00 normally
//   fault      out : sticky until reset
//   state      out : current FSM state (sprinkler_pkg::state_t encoding)
// Handshake: there is no valid/ready pair here. load_pulse and cnt_tick are
// single-cycle strobes the counter must act on at the following edge; the
// counter's digits are assumed synchronous to clk and are sampled every cycle.
module sprinkler_cycle_controller
    import sprinkler_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int WATCHDOG_TICKS = 3,
    parameter int COOLDOWN_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_req,
    input  logic       abort,
    input  logic [3:0] cnt_tens,
    input  logic [3:0] cnt_units,
    output logic       load_pulse,
    output logic       cnt_tick,
    output logic       valve_on,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);

    localparam int WD_W = $clog2(WATCHDOG_TICKS + 1);
    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_TICKS);
    localparam logic [CD_W-1:0] CD_LAST  = CD_W'(COOLDOWN_TICKS - 1);

    state_t state_q, state_d;

    logic load_pulse_q, valve_on_q, busy_q, done_q, fault_q;
    logic done_d;

    logic presc_tick, presc_clear, presc_en;

    logic [7:0]      snap_q;
    logic            snap_valid_q;
    logic [WD_W-1:0] stall_q;
    logic [WD_W-1:0] stall_inc;
    logic [CD_W-1:0] cd_q;

    logic digits_ok, count_zero, count_same, stall_hit, cd_last;

    assign digits_ok  = is_bcd(cnt_tens) && is_bcd(cnt_units);
    assign count_zero = (cnt_tens == BCD_ZERO) && (cnt_units == BCD_ZERO);
    assign count_same = ({cnt_tens, cnt_units} == snap_q);
    assign stall_inc  = stall_q + WD_W'(1);
    // The first tick after entering IRRIGATE only takes a snapshot; from the
    // second tick on, an unchanged count advances the stall counter.
    assign stall_hit  = presc_tick && snap_valid_q && count_same && (stall_inc == WD_LIMIT);
    assign cd_last    = presc_tick && (cd_q == CD_LAST);

    // Every state change restarts the prescaler, so both IRRIGATE and
    // COOLDOWN start their tick timing from zero.
    assign presc_clear = (state_d != state_q);
    assign presc_en    = (state_q == ST_IRRIGATE) || (state_q == ST_COOLDOWN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .en    (presc_en),
        .tick  (presc_tick)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!digits_ok || count_zero) state_d = ST_FAULT;
                else                          state_d = ST_IRRIGATE;
            end
            ST_IRRIGATE: begin
                if (abort) begin
                    state_d = ST_COOLDOWN;
                end else if (!digits_ok) begin
                    state_d = ST_FAULT;
                end else if (count_zero) begin
                    state_d = ST_COOLDOWN;
                    done_d  = 1'b1;
                end else if (stall_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_COOLDOWN: begin
                if (cd_last) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Outputs are flops loaded from the next state so they line up with the
    // state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            load_pulse_q <= 1'b0;
            valve_on_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_pulse_q <= (state_d == ST_LOAD);
            valve_on_q   <= (state_d == ST_IRRIGATE);
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
            done_q       <= done_d;
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    // Watchdog: snapshot and stall counter live only while irrigating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            stall_q      <= '0;
        end else if (state_q != ST_IRRIGATE) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            stall_q      <= '0;
        end else if (presc_tick) begin
            snap_q       <= {cnt_tens, cnt_units};
            snap_valid_q <= 1'b1;
            stall_q      <= (snap_valid_q && count_same) ? stall_inc : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd_q <= '0;
        end else if (state_q != ST_COOLDOWN) begin
            cd_q <= '0;
        end else if (presc_tick) begin
            cd_q <= cd_q + CD_W'(1);
        end
    end

    assign load_pulse = load_pulse_q;
    assign cnt_tick   = presc_tick && (state_q == ST_IRRIGATE);
    assign valve_on   = valve_on_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sprinkler_cycle_controller.sv
module tb_sprinkler_cycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_req = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_units;
    logic       load_pulse, cnt_tick, valve_on, busy, done, fault;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // counter model controls
    logic [7:0] preset = 8'h12;
    logic       freeze_at_07 = 1'b0;
    logic       force_bad = 1'b0;
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_units = 4'd0;

    int n_ticks, first_tick, exit_at, busy_low_at;
    logic exit_done;

    sprinkler_cycle_controller #(
        .TICK_DIV       (4),
        .WATCHDOG_TICKS (3),
        .COOLDOWN_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_req  (start_req),
        .abort      (abort),
        .cnt_tens   (cnt_tens),
        .cnt_units  (cnt_units),
        .load_pulse (load_pulse),
        .cnt_tick   (cnt_tick),
        .valve_on   (valve_on),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .state      (state)
    );

    // clock
    always #5 clk = ~clk;

    // BCD down-counter model: presets on load_pulse, decrements on cnt_tick
    always @(posedge clk) begin
        if (load_pulse) begin
            m_tens  <= preset[7:4];
            m_units <= preset[3:0];
        end else if (cnt_tick && !(freeze_at_07 && m_tens == 4'd0 && m_units == 4'd7)) begin
            if (m_units == 4'd0) begin
                m_units <= 4'd9;
                m_tens  <= m_tens - 4'd1;
            end else begin
                m_units <= m_units - 4'd1;
            end
        end
    end

    assign cnt_tens  = m_tens;
    assign cnt_units = force_bad ? 4'hB : m_units;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // From an IDLE negedge: pulse start_req and step through LOAD and SETTLE.
    task automatic kick();
        start_req = 1'b1;
        @(negedge clk);
        check("load_state", state, 32'd1);
        check("load_pulse_hi", load_pulse, 32'd1);
        start_req = 1'b0;
        @(negedge clk);
        check("settle_state", state, 32'd2);
        check("load_pulse_lo", load_pulse, 32'd0);
        @(negedge clk);
    endtask

    // From IRRIGATE cycle 0: count ticks until the state leaves IRRIGATE.
    task automatic run_irrigate(input int max_cyc, output int ticks, output int first,
                                output int exit_idx, output logic exit_dn);
        ticks = 0;
        first = -1;
        exit_idx = -1;
        exit_dn = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (state != 3'd3) begin
                exit_idx = i;
                exit_dn = done;
                break;
            end
            if (cnt_tick) begin
                if (ticks == 0) first = i;
                ticks++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_state", state, 32'd0);
        check("rst_valve", valve_on, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_fault", fault, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_load", load_pulse, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_tick", cnt_tick, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---- normal cycle
        kick();
        check("norm_irr_state", state, 32'd3);
        check("norm_valve_on", valve_on, 32'd1);
        check("norm_busy", busy, 32'd1);
        run_irrigate(200, n_ticks, first_tick, exit_at, exit_done);
        check("norm_ticks", n_ticks, 32'd12);
        check("norm_first_tick", first_tick, 32'd3);
        check("norm_exit_idx", exit_at, 32'd49);
        check("norm_done", exit_done, 32'd1);
        check("norm_cd_state", state, 32'd4);
        check("norm_valve_off", valve_on, 32'd0);
        check("norm_count00", {m_tens, m_units}, 32'h00);
        busy_low_at = -1;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) check("norm_done_1cyc", done, 32'd0);
            if (!busy) begin
                busy_low_at = i;
                break;
            end
        end
        check("norm_busy_low", busy_low_at, 32'd8);
        check("norm_idle", state, 32'd0);

        // ---- abort after 3 ticks
        kick();
        n_ticks = 0;
        for (int i = 0; i < 40 && n_ticks < 3; i++) begin
            if (cnt_tick) n_ticks++;
            if (n_ticks < 3) @(negedge clk);
        end
        check("abort_ticks", n_ticks, 32'd3);
        abort = 1'b1;
        @(negedge clk);
        check("abort_state", state, 32'd4);
        check("abort_valve", valve_on, 32'd0);
        check("abort_no_done", done, 32'd0);
        abort = 1'b0;
        freeze_at_07 = 1'b1;
        @(negedge clk);
        start_req = 1'b1;  // held through cooldown: ignored until IDLE
        repeat (6) @(negedge clk);
        check("abort_cd_hold", state, 32'd4);
        @(negedge clk);
        check("abort_idle", state, 32'd0);
        @(negedge clk);
        check("restart_load", state, 32'd1);
        start_req = 1'b0;
        @(negedge clk);
        check("restart_settle", state, 32'd2);
        @(negedge clk);

        // ---- stall: counter sticks at 07
        check("stall_irr", state, 32'd3);
        run_irrigate(200, n_ticks, first_tick, exit_at, exit_done);
        check("stall_ticks", n_ticks, 32'd9);
        check("stall_exit_idx", exit_at, 32'd36);
        check("stall_state", state, 32'd5);
        check("stall_fault", fault, 32'd1);
        check("stall_busy", busy, 32'd0);
        check("stall_valve", valve_on, 32'd0);
        check("stall_no_done", exit_done, 32'd0);
        start_req = 1'b1;
        repeat (4) @(negedge clk);
        check("fault_sticky", state, 32'd5);
        check("fault_no_load", load_pulse, 32'd0);
        start_req = 1'b0;
        freeze_at_07 = 1'b0;

        // ---- bad load: preset 00
        do_reset();
        check("post_rst_fault", fault, 32'd0);
        preset = 8'h00;
        kick();
        check("badload_state", state, 32'd5);
        check("badload_valve", valve_on, 32'd0);
        check("badload_fault", fault, 32'd1);
        preset = 8'h12;

        // ---- bad BCD during irrigation
        do_reset();
        kick();
        check("badbcd_irr", state, 32'd3);
        repeat (5) @(negedge clk);
        force_bad = 1'b1;
        @(negedge clk);
        check("badbcd_state", state, 32'd5);
        check("badbcd_valve", valve_on, 32'd0);
        check("badbcd_fault", fault, 32'd1);
        force_bad = 1'b0;

        // ---- reset mid-cycle
        do_reset();
        kick();
        repeat (6) @(negedge clk);
        check("midrst_valve_pre", valve_on, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_valve", valve_on, 32'd0);
        check("midrst_state", state, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_tick", cnt_tick, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        kick();
        run_irrigate(200, n_ticks, first_tick, exit_at, exit_done);
        check("rerun_ticks", n_ticks, 32'd12);
        check("rerun_exit_idx", exit_at, 32'd49);
        check("rerun_done", exit_done, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
